of_action_queue: RTL and testbench

//  Buffers per-packet lookup results (action data/ctrl, hit flag) produced by the matcher and

---
 rtl/of_action_queue.sv | 145 ++++++++++++++
 tb/tb_of_action_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/of_action_queue.sv
// of_action_queue: FWFT queue of matcher lookup results feeding the action processor.
// A miss substitutes MISS_CTRL with zero data. Saturating hit, miss and drop counters.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   action_data_bus/ctrl_bus          lookup result from the matcher
//   action_valid, action_hit          result strobe and its hit/miss qualifier
//   out_data/out_ctrl/out_hit/out_vld head entry, registered
//   out_rd                            pop head (ignored while out_vld = 0)
//   depth_used, full                  occupancy
//   cnt_clr                           clear all counters
//   hit_cnt, miss_cnt, drop_cnt       statistics counters
`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 8
`endif

module of_action_queue #(
    parameter int unsigned DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter logic [CTRL_WIDTH-1:0] MISS_CTRL = '0,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    action_data_bus,
    input  logic [CTRL_WIDTH-1:0]    action_ctrl_bus,
    input  logic                     action_valid,
    input  logic                     action_hit,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CTRL_WIDTH-1:0]    out_ctrl,
    output logic                     out_hit,
    output logic                     out_vld,
    input  logic                     out_rd,
    output logic [$clog2(DEPTH):0]   depth_used,
    output logic                     full,
    input  logic                     cnt_clr,
    output logic [CNT_WIDTH-1:0]     hit_cnt,
    output logic [CNT_WIDTH-1:0]     miss_cnt,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned DU_W  = PTR_W + 1;
    localparam logic [DU_W-1:0] DEPTH_DU = DU_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [CTRL_WIDTH-1:0] mem_ctrl [DEPTH];
    logic                  mem_hit  [DEPTH];

    logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [DU_W-1:0]       depth_nxt;
    logic                  pop, accept, drop;
    logic [DATA_WIDTH-1:0] wr_data, head_data_nxt;
    logic [CTRL_WIDTH-1:0] wr_ctrl, head_ctrl_nxt;
    logic                  wr_hit, head_hit_nxt;
    logic [CNT_WIDTH-1:0]  hit_cnt_nxt, miss_cnt_nxt, drop_cnt_nxt;

    // Next-state: handshake, pointers, occupancy, next head and counters
    always_comb begin
        pop           = out_rd && out_vld;
        accept        = action_valid && (!full || pop);
        drop          = action_valid && full && !pop;
        wr_data       = action_hit ? action_data_bus : '0;
        wr_ctrl       = action_hit ? action_ctrl_bus : MISS_CTRL;
        wr_hit        = action_hit;
        rd_ptr_nxt    = rd_ptr + PTR_W'(pop);
        wr_ptr_nxt    = wr_ptr + PTR_W'(accept);
        depth_nxt     = depth_used + DU_W'(accept) - DU_W'(pop);
        head_data_nxt = '0;
        head_ctrl_nxt = '0;
        head_hit_nxt  = 1'b0;
        hit_cnt_nxt   = hit_cnt;
        miss_cnt_nxt  = miss_cnt;
        drop_cnt_nxt  = drop_cnt;

        // The entry being written this cycle becomes head only when it lands at rd_ptr_nxt
        if (depth_nxt != '0) begin
            if (accept && (wr_ptr == rd_ptr_nxt)) begin
                head_data_nxt = wr_data;
                head_ctrl_nxt = wr_ctrl;
                head_hit_nxt  = wr_hit;
            end else begin
                head_data_nxt = mem_data[rd_ptr_nxt];
                head_ctrl_nxt = mem_ctrl[rd_ptr_nxt];
                head_hit_nxt  = mem_hit[rd_ptr_nxt];
            end
        end

        // Clear wins over increment; increments saturate at all-ones
        if (cnt_clr) begin
            hit_cnt_nxt  = '0;
            miss_cnt_nxt = '0;
            drop_cnt_nxt = '0;
        end else begin
            if (accept && action_hit && (hit_cnt != '1))
                hit_cnt_nxt = hit_cnt + CNT_WIDTH'(1);
            if (accept && !action_hit && (miss_cnt != '1))
                miss_cnt_nxt = miss_cnt + CNT_WIDTH'(1);
            if (drop && (drop_cnt != '1))
                drop_cnt_nxt = drop_cnt + CNT_WIDTH'(1);
        end
    end

    // Control, head and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            depth_used <= '0;
            full       <= 1'b0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            out_hit    <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            depth_used <= depth_nxt;
            full       <= (depth_nxt == DEPTH_DU);
            out_vld    <= (depth_nxt != '0);
            out_data   <= head_data_nxt;
            out_ctrl   <= head_ctrl_nxt;
            out_hit    <= head_hit_nxt;
            hit_cnt    <= hit_cnt_nxt;
            miss_cnt   <= miss_cnt_nxt;
            drop_cnt   <= drop_cnt_nxt;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr] <= wr_data;
            mem_ctrl[wr_ptr] <= wr_ctrl;
            mem_hit[wr_ptr]  <= wr_hit;
        end
    end

endmodule

// File: tb/tb_of_action_queue.sv
// Testbench for of_action_queue: directed vector table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_of_action_queue;

    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int NW    = 4;
    localparam int CMAX  = (1 << NW) - 1;
    localparam logic [CW-1:0] MISS = 4'hC;

    logic          clk = 1'b0;
    logic          reset, action_valid, action_hit, out_rd, cnt_clr;
    logic [DW-1:0] action_data_bus, out_data;
    logic [CW-1:0] action_ctrl_bus, out_ctrl;
    logic          out_hit, out_vld, full;
    logic [2:0]    depth_used;
    logic [NW-1:0] hit_cnt, miss_cnt, drop_cnt;

    of_action_queue #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DEPTH), .MISS_CTRL(MISS), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .reset(reset),
        .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus),
        .action_valid(action_valid), .action_hit(action_hit),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_hit(out_hit), .out_vld(out_vld),
        .out_rd(out_rd), .depth_used(depth_used), .full(full), .cnt_clr(cnt_clr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          h;
    } ent_t;

    ent_t q[$];
    int   m_hit, m_miss, m_drop;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: results are a FIFO of records; pops happen before pushes within a cycle
    task automatic model_step(input logic v, input logic h, input logic [DW-1:0] d,
                              input logic [CW-1:0] c, input logic rd, input logic clr,
                              input logic rst);
        bit   do_pop, do_acc;
        ent_t e;
        if (rst) begin
            q.delete();
            m_hit = 0; m_miss = 0; m_drop = 0;
            return;
        end
        do_pop = rd && (q.size() > 0);
        do_acc = v && ((q.size() < DEPTH) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_acc) begin
            e.h = h;
            e.d = h ? d : '0;
            e.c = h ? c : MISS;
            q.push_back(e);
        end
        if (clr) begin
            m_hit = 0; m_miss = 0; m_drop = 0;
        end else begin
            if (do_acc && h)  m_hit  = (m_hit  < CMAX) ? m_hit  + 1 : CMAX;
            if (do_acc && !h) m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
            if (v && !do_acc) m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
        end
    endtask

    task automatic check_model();
        ent_t hd;
        hd.d = '0; hd.c = '0; hd.h = 1'b0;
        if (q.size() > 0) hd = q[0];
        chk("out_vld",    32'(out_vld),    32'(q.size() > 0));
        chk("out_data",   32'(out_data),   32'(hd.d));
        chk("out_ctrl",   32'(out_ctrl),   32'(hd.c));
        chk("out_hit",    32'(out_hit),    32'(hd.h));
        chk("depth_used", 32'(depth_used), 32'(q.size()));
        chk("full",       32'(full),       32'(q.size() == DEPTH));
        chk("hit_cnt",    32'(hit_cnt),    32'(m_hit));
        chk("miss_cnt",   32'(miss_cnt),   32'(m_miss));
        chk("drop_cnt",   32'(drop_cnt),   32'(m_drop));
    endtask

    // One clock: drive, step model at the edge, compare 1 time unit later
    task automatic cycle(input logic v, input logic h, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic rd, input logic clr,
                         input logic rst);
        action_valid = v; action_hit = h; action_data_bus = d; action_ctrl_bus = c;
        out_rd = rd; cnt_clr = clr; reset = rst;
        @(posedge clk);
        model_step(v, h, d, c, rd, clr, rst);
        #1;
        check_model();
    endtask

    typedef struct {
        logic          v, h;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          rd;
        logic          e_vld;
        logic [DW-1:0] e_d;
        logic [CW-1:0] e_c;
        logic          e_h;
        int            e_depth;
        logic          e_full;
    } vec_t;

    vec_t vt[13];
    logic [DW-1:0] s4_list[16];

    initial begin
        // v h data ctrl rd | vld data ctrl hit depth full
        vt[0]  = '{1, 1, 8'hA5, 4'h3, 0,  1, 8'hA5, 4'h3, 1, 1, 0};
        vt[1]  = '{0, 0, 8'h00, 4'h0, 1,  0, 8'h00, 4'h0, 0, 0, 0};
        vt[2]  = '{1, 0, 8'hFF, 4'h7, 0,  1, 8'h00, MISS, 0, 1, 0};
        vt[3]  = '{0, 0, 8'h00, 4'h0, 1,  0, 8'h00, 4'h0, 0, 0, 0};
        vt[4]  = '{1, 1, 8'h01, 4'h1, 0,  1, 8'h01, 4'h1, 1, 1, 0};
        vt[5]  = '{1, 1, 8'h02, 4'h2, 0,  1, 8'h01, 4'h1, 1, 2, 0};
        vt[6]  = '{1, 1, 8'h03, 4'h3, 0,  1, 8'h01, 4'h1, 1, 3, 0};
        vt[7]  = '{1, 1, 8'h04, 4'h4, 0,  1, 8'h01, 4'h1, 1, 4, 1};
        vt[8]  = '{1, 1, 8'h05, 4'h5, 0,  1, 8'h01, 4'h1, 1, 4, 1};
        vt[9]  = '{0, 0, 8'h00, 4'h0, 1,  1, 8'h02, 4'h2, 1, 3, 0};
        vt[10] = '{0, 0, 8'h00, 4'h0, 1,  1, 8'h03, 4'h3, 1, 2, 0};
        vt[11] = '{0, 0, 8'h00, 4'h0, 1,  1, 8'h04, 4'h4, 1, 1, 0};
        vt[12] = '{0, 0, 8'h00, 4'h0, 1,  0, 8'h00, 4'h0, 0, 0, 0};

        // Reset state
        cycle(0, 0, '0, '0, 0, 0, 1);
        cycle(0, 0, '0, '0, 0, 0, 1);
        chk("rst_vld",   32'(out_vld),    32'(0));
        chk("rst_depth", 32'(depth_used), 32'(0));
        chk("rst_full",  32'(full),       32'(0));
        chk("rst_hits",  32'(hit_cnt),    32'(0));

        // Scenarios 1-3 from the vector table
        foreach (vt[i]) begin
            cycle(vt[i].v, vt[i].h, vt[i].d, vt[i].c, vt[i].rd, 0, 0);
            chk("tbl_vld",   32'(out_vld),    32'(vt[i].e_vld));
            chk("tbl_data",  32'(out_data),   32'(vt[i].e_d));
            chk("tbl_ctrl",  32'(out_ctrl),   32'(vt[i].e_c));
            chk("tbl_hit",   32'(out_hit),    32'(vt[i].e_h));
            chk("tbl_depth", 32'(depth_used), 32'(vt[i].e_depth));
            chk("tbl_full",  32'(full),       32'(vt[i].e_full));
        end
        chk("tbl_hit_cnt",  32'(hit_cnt),  32'(5));
        chk("tbl_miss_cnt", 32'(miss_cnt), 32'(1));
        chk("tbl_drop_cnt", 32'(drop_cnt), 32'(1));

        // Scenario 4: fill, then 12 simultaneous write+pop at full, then drain
        for (int i = 0; i < 16; i++) s4_list[i] = DW'(8'h10 + i);
        for (int i = 0; i < 4; i++) cycle(1, 1, s4_list[i], CW'(i), 0, 0, 0);
        chk("s4_full", 32'(full), 32'(1));
        for (int i = 0; i < 12; i++) begin
            chk("s4_order", 32'(out_data), 32'(s4_list[i]));
            cycle(1, 1, s4_list[i+4], CW'(i), 1, 0, 0);
            chk("s4_depth", 32'(depth_used), 32'(4));
        end
        for (int i = 12; i < 16; i++) begin
            chk("s4_order", 32'(out_data), 32'(s4_list[i]));
            cycle(0, 0, '0, '0, 1, 0, 0);
        end
        chk("s4_empty", 32'(out_vld), 32'(0));

        // Scenario 5: hit counter is already saturated; clear wins over a same-cycle hit
        cycle(1, 1, 8'h55, 4'h1, 0, 0, 0);
        chk("sat_hit", 32'(hit_cnt), 32'(CMAX));
        cycle(1, 1, 8'h66, 4'h2, 1, 1, 0);
        chk("clr_hit",  32'(hit_cnt),  32'(0));
        chk("clr_drop", 32'(drop_cnt), 32'(0));
        chk("clr_keepq", 32'(depth_used), 32'(1));
        cycle(0, 0, '0, '0, 1, 0, 0);

        // Scenario 6: reset with 3 entries queued, then a fresh hit
        for (int i = 0; i < 3; i++) cycle(1, 1, DW'(8'h70 + i), 4'h6, 0, 0, 0);
        cycle(0, 0, '0, '0, 0, 0, 1);
        chk("mid_rst_vld",   32'(out_vld),    32'(0));
        chk("mid_rst_depth", 32'(depth_used), 32'(0));
        chk("mid_rst_hits",  32'(hit_cnt),    32'(0));
        cycle(1, 1, 8'hA5, 4'h3, 0, 0, 0);
        chk("post_rst_data", 32'(out_data), 32'(8'hA5));
        chk("post_rst_hit",  32'(out_hit),  32'(1));
        cycle(0, 0, '0, '0, 1, 0, 0);
        chk("post_rst_vld",  32'(out_vld), 32'(0));
        chk("post_rst_cnt",  32'(hit_cnt), 32'(1));

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  DW'($urandom), CW'($urandom), 1'($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 199) < 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
